regfile_nrp: RTL and testbench



---
 rtl/cpu_pkg.sv | 12 +
 rtl/regfile_rd_mux.sv | 32 +++
 rtl/regfile_nrp.sv | 138 +++++++++++++
 tb/tb_regfile_nrp.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU datapath package: register-file sequencer state encoding and size limits.
package cpu_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_t;

  localparam int RF_MAX_DEPTH = 256;
  localparam int RF_MAX_RD    = 4;

endpackage

// File: rtl/regfile_rd_mux.sv
// Stateless DEPTH:1 entry selector over a flat register bus.
// An address past the last entry yields zero rather than aliasing.
module regfile_rd_mux
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic [DEPTH*WIDTH-1:0] bus,
  input  logic [AW-1:0]          addr,
  output logic [WIDTH-1:0]       data
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] ent_s [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_unpack
    assign ent_s[i] = bus[i*WIDTH +: WIDTH];
  end

  // Select the addressed entry, zero when the address is beyond DEPTH-1.
  always_comb begin
    if ({1'b0, addr} < DEPTH_W) begin
      data = ent_s[addr];
    end else begin
      data = '0;
    end
  end

endmodule

// File: rtl/regfile_nrp.sv
// Parametrised register file: NRD combinational read ports, one write port,
// optional hardwired-zero entry 0, write-to-read bypass and a post-reset clear sweep.
module regfile_nrp
  import cpu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = $clog2(DEPTH),
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                 Clk,
  input  logic                 Clrn,
  input  logic                 We,
  input  logic [AW-1:0]        Wa,
  input  logic [WIDTH-1:0]     Wd,
  input  logic [NRD*AW-1:0]    Ra,
  output logic [NRD*WIDTH-1:0] Rd,
  output logic                 Busy
);

  localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_CNT = AW'(DEPTH - 1);

  if (DEPTH < 2 || DEPTH > RF_MAX_DEPTH || NRD < 1 || NRD > RF_MAX_RD) begin : g_bad_param
    $error("regfile_nrp: DEPTH or NRD outside supported range");
  end

  rf_state_t              state_r;
  logic [AW-1:0]          cnt_r;
  logic                   clr_en_s;
  logic                   wr_en_s;
  logic [DEPTH*WIDTH-1:0] mem_flat_s;

  // Clear sequencer: reset parks at CLEAR, then one entry is zeroed per cycle.
  always_ff @(posedge Clk) begin
    if (!Clrn) begin
      state_r <= CLEAR;
      cnt_r   <= '0;
      Busy    <= 1'b1;
    end else begin
      case (state_r)
        CLEAR: begin
          if (cnt_r == LAST_CNT) begin
            state_r <= RUN;
            cnt_r   <= '0;
            Busy    <= 1'b0;
          end else begin
            cnt_r   <= cnt_r + AW'(1);
            Busy    <= 1'b1;
          end
        end
        RUN: begin
          state_r <= RUN;
          Busy    <= 1'b0;
        end
        default: begin
          state_r <= CLEAR;
          cnt_r   <= '0;
          Busy    <= 1'b1;
        end
      endcase
    end
  end

  assign clr_en_s = Clrn && (state_r == CLEAR);

  // Write qualification: RUN only, in-range address, entry 0 read-only when hardwired.
  always_comb begin
    if (Clrn && (state_r == RUN) && We && ({1'b0, Wa} < DEPTH_W)) begin
      if ((ZERO_REG != 0) && (Wa == '0)) begin
        wr_en_s = 1'b0;
      end else begin
        wr_en_s = 1'b1;
      end
    end else begin
      wr_en_s = 1'b0;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    if ((ZERO_REG != 0) && (i == 0)) begin : g_zero
      assign mem_flat_s[i*WIDTH +: WIDTH] = '0;
    end else begin : g_reg
      logic [WIDTH-1:0] q_r;

      // Entry storage: sweep clear takes precedence, reset edge leaves contents alone.
      always_ff @(posedge Clk) begin
        if (clr_en_s && (cnt_r == AW'(i))) begin
          q_r <= '0;
        end else if (wr_en_s && (Wa == AW'(i))) begin
          q_r <= Wd;
        end else begin
          q_r <= q_r;
        end
      end

      assign mem_flat_s[i*WIDTH +: WIDTH] = q_r;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]    ra_s;
    logic [WIDTH-1:0] mux_s;
    logic [WIDTH-1:0] rd_s;

    assign ra_s = Ra[k*AW +: AW];

    regfile_rd_mux #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
    ) u_mux (
      .bus  (mem_flat_s),
      .addr (ra_s),
      .data (mux_s)
    );

    // Read masking and bypass, highest priority first.
    always_comb begin
      if (Busy) begin
        rd_s = '0;
      end else if ({1'b0, ra_s} >= DEPTH_W) begin
        rd_s = '0;
      end else if ((ZERO_REG != 0) && (ra_s == '0)) begin
        rd_s = '0;
      end else if ((BYPASS != 0) && wr_en_s && (Wa == ra_s)) begin
        rd_s = Wd;
      end else begin
        rd_s = mux_s;
      end
    end

    assign Rd[k*WIDTH +: WIDTH] = rd_s;
  end

endmodule

// File: tb/tb_regfile_nrp.sv
// Self-checking bench for regfile_nrp: directed scenarios on three configurations
// plus a randomized regression against an array-based reference model.
module tb_regfile_nrp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clrn, we, busy;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [9:0]  ra;
  logic [63:0] rd;

  logic        nb_clrn, nb_we, nb_busy;
  logic [4:0]  nb_wa;
  logic [31:0] nb_wd;
  logic [9:0]  nb_ra;
  logic [63:0] nb_rd;

  logic        o_clrn, o_we, o_busy;
  logic [4:0]  o_wa;
  logic [15:0] o_wd;
  logic [14:0] o_ra;
  logic [47:0] o_rd;

  regfile_nrp dut (
    .Clk(clk), .Clrn(clrn), .We(we), .Wa(wa), .Wd(wd), .Ra(ra), .Rd(rd), .Busy(busy)
  );

  regfile_nrp #(.BYPASS(0)) dut_nb (
    .Clk(clk), .Clrn(nb_clrn), .We(nb_we), .Wa(nb_wa), .Wd(nb_wd), .Ra(nb_ra), .Rd(nb_rd),
    .Busy(nb_busy)
  );

  regfile_nrp #(.WIDTH(16), .DEPTH(20), .NRD(3)) dut_odd (
    .Clk(clk), .Clrn(o_clrn), .We(o_we), .Wa(o_wa), .Wd(o_wd), .Ra(o_ra), .Rd(o_rd),
    .Busy(o_busy)
  );

  // Reference model of the default instance: contents plus remaining sweep cycles.
  logic [31:0] mmem [32];
  bit          mbusy;
  int          mleft;
  int          n_checks;
  int          n_fail;

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (mbusy) return 32'h0;
    if (a == 5'd0) return 32'h0;
    if (clrn && we && (wa != 5'd0) && (wa == a)) return wd;
    return mmem[a];
  endfunction

  // Advance one clock and apply the model's view of that edge.
  task automatic tick();
    @(posedge clk);
    if (!clrn) begin
      mbusy = 1'b1;
      mleft = 32;
    end else if (mbusy) begin
      mleft = mleft - 1;
      if (mleft == 0) begin
        mbusy = 1'b0;
        for (int i = 0; i < 32; i++) mmem[i] = 32'h0;
      end
    end else if (we && (wa != 5'd0)) begin
      mmem[wa] = wd;
    end
    #1;
  endtask

  task automatic test_reset();
    int nbusy;
    clrn = 1'b0; we = 1'b0; wa = 5'd0; wd = 32'h0; ra = 10'd0;
    tick();
    tick();
    #1;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy got %b expected 1", busy); end
    n_checks++;
    if (rd !== 64'h0) begin n_fail++; $display("FAIL reset_rd got %h expected 0", rd); end
    clrn = 1'b1;
    nbusy = 0;
    for (int c = 0; c < 40 && busy === 1'b1; c++) begin
      ra = 10'($urandom);
      #1;
      n_checks++;
      if (rd !== 64'h0) begin n_fail++; $display("FAIL sweep_rd got %h expected 0", rd); end
      nbusy++;
      tick();
    end
    n_checks++;
    if (nbusy != 32) begin n_fail++; $display("FAIL sweep_len got %0d expected 32", nbusy); end
    for (int a = 0; a < 32; a++) begin
      ra = {5'(31 - a), 5'(a)};
      #1;
      n_checks++;
      if (rd !== 64'h0) begin n_fail++; $display("FAIL cleared_rd addr %0d got %h expected 0", a, rd); end
    end
  endtask

  task automatic test_write_read();
    we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; ra = 10'd0;
    tick();
    we = 1'b0; ra = {5'd0, 5'd5};
    #1;
    n_checks++;
    if (rd[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL write_read got %h expected deadbeef", rd[31:0]); end
    we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF;
    #1;
    n_checks++;
    if (rd[63:32] !== 32'h0) begin n_fail++; $display("FAIL zero_bypass got %h expected 0", rd[63:32]); end
    tick();
    we = 1'b0;
    #1;
    n_checks++;
    if (rd !== {32'h0, 32'hDEADBEEF}) begin n_fail++; $display("FAIL zero_reg got %h expected 00000000deadbeef", rd); end
  endtask

  task automatic test_bypass();
    we = 1'b1; wa = 5'd7; wd = 32'h12345678; ra = {5'd7, 5'd7};
    #1;
    n_checks++;
    if (rd !== {2{32'h12345678}}) begin n_fail++; $display("FAIL bypass got %h expected 1234567812345678", rd); end
    tick();
    we = 1'b0;
    #1;
    n_checks++;
    if (rd !== {2{32'h12345678}}) begin n_fail++; $display("FAIL bypass_stored got %h expected 1234567812345678", rd); end

    nb_clrn = 1'b0; nb_we = 1'b0; nb_wa = 5'd0; nb_wd = 32'h0; nb_ra = 10'd0;
    tick();
    tick();
    nb_clrn = 1'b1;
    for (int c = 0; c < 40 && nb_busy === 1'b1; c++) tick();
    n_checks++;
    if (nb_busy !== 1'b0) begin n_fail++; $display("FAIL nb_sweep_done got %b expected 0", nb_busy); end
    nb_we = 1'b1; nb_wa = 5'd7; nb_wd = 32'h12345678; nb_ra = {5'd7, 5'd7};
    #1;
    n_checks++;
    if (nb_rd !== 64'h0) begin n_fail++; $display("FAIL no_bypass got %h expected 0", nb_rd); end
    tick();
    nb_we = 1'b0;
    #1;
    n_checks++;
    if (nb_rd !== {2{32'h12345678}}) begin n_fail++; $display("FAIL no_bypass_stored got %h expected 1234567812345678", nb_rd); end
  endtask

  task automatic test_reset_mid_sweep();
    int nbusy;
    clrn = 1'b0; we = 1'b0;
    tick();
    clrn = 1'b1; we = 1'b1; wa = 5'd3; wd = 32'hCAFEF00D; ra = {5'd3, 5'd3};
    for (int c = 0; c < 10; c++) tick();
    #1;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy got %b expected 1", busy); end
    clrn = 1'b0;
    tick();
    clrn = 1'b1;
    nbusy = 0;
    for (int c = 0; c < 40 && busy === 1'b1; c++) begin
      wd = $urandom;
      #1;
      n_checks++;
      if (rd !== 64'h0) begin n_fail++; $display("FAIL mid_rd got %h expected 0", rd); end
      nbusy++;
      tick();
    end
    n_checks++;
    if (nbusy != 32) begin n_fail++; $display("FAIL restart_len got %0d expected 32", nbusy); end
    we = 1'b0;
    #1;
    n_checks++;
    if (rd !== 64'h0) begin n_fail++; $display("FAIL sweep_write got %h expected 0", rd); end
  endtask

  task automatic test_odd_depth();
    int nbusy;
    o_clrn = 1'b0; o_we = 1'b0; o_wa = 5'd0; o_wd = 16'h0; o_ra = 15'd0;
    tick();
    tick();
    o_clrn = 1'b1;
    nbusy = 0;
    for (int c = 0; c < 30 && o_busy === 1'b1; c++) begin
      nbusy++;
      tick();
    end
    n_checks++;
    if (nbusy != 20) begin n_fail++; $display("FAIL odd_sweep_len got %0d expected 20", nbusy); end
    o_we = 1'b1; o_wa = 5'd19; o_wd = 16'hA5A5;
    tick();
    o_we = 1'b0; o_ra = {5'd19, 5'd0, 5'd0};
    #1;
    n_checks++;
    if (o_rd !== {16'hA5A5, 32'h0}) begin n_fail++; $display("FAIL odd_last got %h expected a5a500000000", o_rd); end
    o_we = 1'b1; o_wa = 5'd25; o_wd = 16'hFFFF; o_ra = {5'd25, 5'd25, 5'd25};
    #1;
    n_checks++;
    if (o_rd !== 48'h0) begin n_fail++; $display("FAIL odd_oor_bypass got %h expected 0", o_rd); end
    tick();
    o_we = 1'b0; o_ra = {5'd25, 5'd5, 5'd9};
    #1;
    n_checks++;
    if (o_rd !== 48'h0) begin n_fail++; $display("FAIL odd_oor_write got %h expected 0", o_rd); end
    o_ra = {5'd19, 5'd19, 5'd19};
    #1;
    n_checks++;
    if (o_rd !== {3{16'hA5A5}}) begin n_fail++; $display("FAIL odd_same_addr got %h expected a5a5a5a5a5a5", o_rd); end
  endtask

  task automatic test_random();
    int          rst_left;
    logic [4:0]  ra0, ra1;
    logic [31:0] e0, e1;
    rst_left = 0;
    for (int c = 0; c < 10000; c++) begin
      if (rst_left > 0) begin
        clrn = 1'b0;
        rst_left--;
      end else if ($urandom_range(199) == 0) begin
        clrn = 1'b0;
        rst_left = $urandom_range(2);
      end else begin
        clrn = 1'b1;
      end
      we  = 1'($urandom_range(1));
      wa  = 5'($urandom);
      wd  = $urandom;
      ra0 = ($urandom_range(3) == 0) ? wa : 5'($urandom);
      ra1 = ($urandom_range(3) == 0) ? wa : 5'($urandom);
      ra  = {ra1, ra0};
      #1;
      e0 = exp_rd(ra0);
      e1 = exp_rd(ra1);
      n_checks++;
      if (busy !== mbusy) begin n_fail++; $display("FAIL rand_busy cycle %0d got %b expected %b", c, busy, mbusy); end
      n_checks++;
      if (rd[31:0] !== e0) begin n_fail++; $display("FAIL rand_rd0 cycle %0d addr %0d got %h expected %h", c, ra0, rd[31:0], e0); end
      n_checks++;
      if (rd[63:32] !== e1) begin n_fail++; $display("FAIL rand_rd1 cycle %0d addr %0d got %h expected %h", c, ra1, rd[63:32], e1); end
      tick();
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    mbusy    = 1'b1;
    mleft    = 32;
    for (int i = 0; i < 32; i++) mmem[i] = 32'h0;
    clrn = 1'b0; we = 1'b0; wa = 5'd0; wd = 32'h0; ra = 10'd0;
    nb_clrn = 1'b0; nb_we = 1'b0; nb_wa = 5'd0; nb_wd = 32'h0; nb_ra = 10'd0;
    o_clrn = 1'b0; o_we = 1'b0; o_wa = 5'd0; o_wd = 16'h0; o_ra = 15'd0;
    #2;
    test_reset();
    test_write_read();
    test_bypass();
    test_reset_mid_sweep();
    test_odd_depth();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
